// File: rtl/timer_pkg.sv
// timer_pkg: shared FSM state encoding and default widths for countdown_timer
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_PRESCALE_WIDTH = 22;
    localparam int DEF_WIDTH          = 8;

endpackage

// File: rtl/prescaler.sv
// prescaler: free-running up-counter with enable and clear; tick is the carry-out
//   clk, rst  : clock, synchronous active-high reset
//   ce        : count enable
//   clr       : synchronous clear (wins over ce)
//   count     : current prescaler value
//   tick      : high while count is all-ones and ce is high (wrap on next edge)
module prescaler
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tick
);

    assign tick = ce & (&count);

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (ce)
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter decremented once per prescaler wrap
//   CLK, RESET : clock, synchronous active-high reset
//   LOAD, I    : load strobe and start/reload count (I=0 loads and idles)
//   CE         : count enable, freezes prescaler and count when low
//   AUTO       : at expiry, reload from the stored value instead of stopping
//   O          : remaining count
//   TICK       : prescaler carry, one cycle per wrap while running
//   DONE       : one-cycle pulse the cycle after expiry
//   BUSY       : high while running
module countdown_timer
    import timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH,
    parameter int WIDTH          = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] I,
    input  logic             CE,
    input  logic             AUTO,
    output logic [WIDTH-1:0] O,
    output logic             TICK,
    output logic             DONE,
    output logic             BUSY
);

    state_t                    state, state_n;
    logic [WIDTH-1:0]          reload, reload_n, o_n;
    logic                      done_n, pre_clr;
    logic [PRESCALE_WIDTH-1:0] pre;

    assign BUSY = (state == RUN);

    // Gating the enable with BUSY keeps the prescaler parked at 0 in IDLE,
    // since every entry into IDLE happens on a wrap, a load or a reset.
    prescaler #(.WIDTH(PRESCALE_WIDTH)) u_pre (
        .clk   (CLK),
        .rst   (RESET),
        .ce    (CE & BUSY),
        .clr   (pre_clr),
        .count (pre),
        .tick  (TICK)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            O      <= '0;
            reload <= '0;
            DONE   <= 1'b0;
        end else begin
            state  <= state_n;
            O      <= o_n;
            reload <= reload_n;
            DONE   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        o_n      = O;
        reload_n = reload;
        done_n   = 1'b0;
        pre_clr  = 1'b0;
        if (LOAD) begin
            o_n      = I;
            reload_n = I;
            pre_clr  = 1'b1;
            state_n  = (I != '0) ? RUN : IDLE;
        end else if (TICK) begin
            if (O == WIDTH'(1)) begin
                done_n  = 1'b1;
                o_n     = AUTO ? reload : '0;
                state_n = AUTO ? RUN : IDLE;
            end else begin
                o_n = O - WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter PRESCALE_WIDTH, default 22, giving prescaler width; a tick occurs every 2**PRESCALE_WIDTH enabled cycles.
REQ-002 SHALL have parameter WIDTH, default 8, giving countdown register width.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port LOAD  input  1  one-cycle strobe; captures I as start and reload value.
REQ-006 SHALL have port I  input  WIDTH  start/reload count.
REQ-007 SHALL have port CE  input  1  count enable; low freezes prescaler and count.
REQ-008 SHALL have port AUTO  input  1  auto-reload mode select, sampled at expiry.
REQ-009 SHALL have port O  output  WIDTH  current remaining count.
REQ-010 SHALL have port TICK  output  1  prescaler carry, high one cycle per prescaler wrap.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse when count expires.
REQ-012 SHALL have port BUSY  output  1  high while in RUN.

Function
REQ-013 SHALL implement FSM states IDLE and RUN; EXPIRE is a transition event, not a held state.
REQ-014 SHALL hold prescaler at 0 and O constant in IDLE; TICK low, BUSY low.
REQ-015 SHALL in RUN with CE=1 increment prescaler by 1 each cycle, wrapping all-ones -> 0.
REQ-016 SHALL assert TICK combinationally in the cycle prescaler equals all-ones with CE=1 in RUN (carry-out semantics).
REQ-017 SHALL decrement O by 1 on the clock edge where TICK=1.
REQ-018 SHALL on LOAD with I!=0 set O=I, store I in reload register, clear prescaler, enter RUN next cycle.
REQ-019 SHALL on LOAD with I=0 set O=0, clear prescaler, enter IDLE, no DONE pulse.
REQ-020 SHALL give LOAD priority over TICK, CE and expiry in the same cycle.
REQ-021 SHALL on TICK with O=1 (expiry) register DONE=1 for exactly the following cycle.
REQ-022 SHALL at expiry with AUTO=0 set O=0 and enter IDLE.
REQ-023 SHALL at expiry with AUTO=1 set O=reload value and remain in RUN; prescaler continues wrapping.
REQ-024 SHALL keep CE=0 from affecting pending DONE; DONE still deasserts after one cycle.
REQ-025 SHALL ignore CE, AUTO and TICK generation in IDLE.
REQ-026 SHALL decrement-to-expiry latency equal O_loaded * 2**PRESCALE_WIDTH enabled cycles after the LOAD edge.
REQ-027 SHALL never underflow: O=0 in RUN is unreachable; O wraps never.

Reset
REQ-028 SHALL on RESET=1 at clock edge set state IDLE, O=0, reload=0, prescaler=0, DONE=0.
REQ-029 SHALL give RESET priority over LOAD and TICK; reset mid-RUN aborts count with no DONE.
REQ-030 SHALL drive TICK=0 and BUSY=0 in the cycle after reset.

Structure
REQ-031 SHALL place state encoding (IDLE, RUN) and default widths in shared package timer_pkg.
REQ-032 SHALL implement prescaler as sub-module prescaler (free-running up-counter with CE, clear, carry-out TICK).
REQ-033 SHALL map registers onto enabled flip-flops with synchronous reset; no latches, no derived clocks.

Verification (PRESCALE_WIDTH=2, WIDTH=8 unless stated)
REQ-034 SHALL test basic countdown: LOAD I=3, CE=1, AUTO=0 -> O 3,2,1,0 at 4-cycle spacing, DONE one cycle at cycle 13 after LOAD, BUSY low thereafter.
REQ-035 SHALL test auto-reload: LOAD I=2, AUTO=1 -> DONE every 8 cycles, O sequence 2,1,2,1..., BUSY stays high.
REQ-036 SHALL test CE gating: LOAD I=2, CE low for 5 cycles mid-count -> DONE delayed by exactly 5 cycles, prescaler value frozen.
REQ-037 SHALL test LOAD priority: LOAD I=5 in the expiry-tick cycle -> O=5, no DONE, prescaler 0.
REQ-038 SHALL test reset mid-run: RESET at O=2 -> O=0, IDLE, no DONE; LOAD I=0 -> IDLE, no DONE.
REQ-039 SHALL test default parameters: LOAD I=1 -> DONE exactly 4194304 cycles after LOAD (one tick interval).
